dcache_flush_ctrl: RTL and testbench
====================================

Name: dcache_flush_ctrl

Overview:
- Flush/refill controller that drives the flush port of one data-cache line and the main-memory port.
- On a CPU access that hits a missing line, it stalls the core and, if the line is dirty, writes the old contents back to memory.
- It then refills all 2^CACHEADDRBITS words of the new section through flush_we and releases the stall.
- Sits between the cache line and the memory arbiter; one instance per line.

Parameters:
DATABITS, 32, width of a data word
ADDRBITS, 32, byte address width
CACHEADDRBITS, 5, log2 of words per line; word counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
dcache_addr  in  ADDRBITS  CPU byte address
dcache_rdreq  in  1  CPU read request
dcache_wrreq  in  1  CPU write request
dcache_stall  out  1  core must hold its request
line_miss  in  1  from line: section mismatch or uninitialised
line_dirty  in  1  from line: modified since last fill
line_out  in  DATABITS  line read data; valid 1 cycle after flush_addr is presented
flush_mode  out  1  line is under controller ownership
flush_we  out  1  write flush_in into line at flush_addr
flush_addr  out  ADDRBITS  {tag, word index, 2'b00}
flush_in  out  DATABITS  refill data
mem_addr  out  ADDRBITS  memory word address, low two bits are 0
mem_rdreq  out  1  memory read request
mem_wrreq  out  1  memory write request
mem_wdata  out  DATABITS  write data
mem_rdata  in  DATABITS  read data, valid with mem_ack on a read
mem_ack  in  1  request accepted/completed; may be high in the request cycle

Behaviour:
- Reset: all outputs 0. State IDLE, cnt=0, old_tag=0, tag_valid=0.
- dcache_stall = (state!=IDLE) | ((dcache_rdreq|dcache_wrreq) & line_miss). This is combinational.
- Tag field: addr[ADDRBITS-1:CACHEADDRBITS+2].
- One memory request is outstanding at most. A request and its address/data are held stable until the cycle mem_ack=1.
- IDLE:
  - On (rd|wr)req & line_miss: latch new_tag from dcache_addr and set cnt=0.
  - Go to WB_RD if line_dirty & tag_valid, else FILL_REQ.
- WB_RD: flush_mode=1, flush_we=0, flush_addr={old_tag,cnt,00}. Go to WB_REQ.
- WB_REQ:
  - Captures line_out into mem_wdata on entry.
  - Drives mem_wrreq=1 and mem_addr={old_tag,cnt,00}.
  - On mem_ack: cnt++. If cnt was all-ones, go to FILL_REQ with cnt=0; else go to WB_RD.
- FILL_REQ: flush_mode=1, mem_rdreq=1, mem_addr={new_tag,cnt,00}. On mem_ack: latch mem_rdata and go to FILL_WR.
- FILL_WR:
  - Drives flush_we=1, flush_addr={new_tag,cnt,00}, flush_in=latched data for one cycle.
  - cnt++. If cnt was all-ones (wrap to 0), go to DONE; else go to FILL_REQ.
- DONE: flush_mode=1, old_tag<=new_tag, tag_valid<=1. Go to IDLE. The line has updated its section, so line_miss is 0 in IDLE.
- Latency with zero-wait mem_ack and N=2^CACHEADDRBITS:
  - clean miss: stall lasts 2N+1 cycles;
  - dirty miss: stall lasts 4N+1 cycles.
- CPU address changes while stalled: the fill uses the latched new_tag. A still-mismatching address causes a fresh miss in IDLE.
- flush_mode stays high continuously from leaving IDLE until DONE; the line ignores CPU writes during it.
- Asynchronous reset mid-operation: immediate return to reset values. The memory request is dropped, no completion is reported, and tag_valid=0.
- mem_ack outside WB_REQ/FILL_REQ is ignored.

Optional Feature:
- Macro: DCACHE_FLUSH_PERFCNT_EN.
- Defined:
  - Adds outputs perf_miss (32 bits) and perf_wb (32 bits), reset to 0.
  - perf_miss increments on each IDLE->miss transition.
  - perf_wb increments on each entry to WB_RD with cnt=0.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared include dcache_defs.vh holds:
  - state encodings: IDLE, WB_RD, WB_REQ, FILL_REQ, FILL_WR, DONE;
  - the tag-slice macros used by line and controller.
- A natural sub-module is dcache_flush_wordcnt: a CACHEADDRBITS counter with clear, increment and last-word flag.

Test Plan (CACHEADDRBITS=2, N=4):
1. Reset, then rdreq addr 0x100 with line_miss=1 -> dcache_stall=1 same cycle; all other outputs 0 before the request.
2. Clean miss at 0x100, mem_ack immediate, mem_rdata 0xA0..0xA3 -> reads at 0x100/104/108/10C; four flush_we pulses with those data; stall for 9 cycles.
3. After test 2, line_dirty=1 and wrreq addr 0x200 -> writes of the line_out values to 0x100..0x10C, then reads at 0x200..0x20C; stall 17 cycles.
4. mem_ack delayed 3 cycles on each read -> mem_rdreq and mem_addr held constant for 4 cycles per word; no extra flush_we.
5. reset_n low during the second WB_REQ -> mem_wrreq, flush_mode and dcache_stall are 0 immediately. The next miss with line_dirty=1 takes the clean path because tag_valid=0.
6. With DCACHE_FLUSH_PERFCNT_EN: tests 2 then 3 -> perf_miss=2, perf_wb=1.

Source files
------------

// File: rtl/dcache_flush_ctrl_pkg.sv
// Shared types for the data-cache line flush/refill controller.
// State encoding and address-field helpers used by line and controller.
package dcache_flush_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WB_RD    = 3'd1,
    S_WB_REQ   = 3'd2,
    S_FILL_REQ = 3'd3,
    S_FILL_WR  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Byte-offset bits below the word index.
  localparam int BYTE_BITS = 2;

  function automatic int tag_lsb(input int cache_addr_bits);
    return cache_addr_bits + BYTE_BITS;
  endfunction

endpackage

// File: rtl/dcache_flush_ctrl_wordcnt.sv
// Word counter for one cache line: clear, increment, last-word flag.
// Wraps to zero after the all-ones word.
module dcache_flush_ctrl_wordcnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         last
);

  assign nxt  = cnt + 1'b1;
  assign last = &cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Flush/refill controller for one data-cache line and the memory port.
// Optional perf counters under DCACHE_FLUSH_PERFCNT_EN.
module dcache_flush_ctrl
  import dcache_flush_ctrl_pkg::*;
#(
  parameter int DATABITS      = 32,
  parameter int ADDRBITS      = 32,
  parameter int CACHEADDRBITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] dcache_addr,
  input  logic                dcache_rdreq,
  input  logic                dcache_wrreq,
  output logic                dcache_stall,
  input  logic                line_miss,
  input  logic                line_dirty,
  input  logic [DATABITS-1:0] line_out,
  output logic                flush_mode,
  output logic                flush_we,
  output logic [ADDRBITS-1:0] flush_addr,
  output logic [DATABITS-1:0] flush_in,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  output logic [DATABITS-1:0] mem_wdata,
  input  logic [DATABITS-1:0] mem_rdata,
  input  logic                mem_ack
`ifdef DCACHE_FLUSH_PERFCNT_EN
  ,
  output logic [31:0]         perf_miss,
  output logic [31:0]         perf_wb
`endif
);

  localparam int TL = tag_lsb(CACHEADDRBITS);
  localparam int TW = ADDRBITS - TL;

  typedef logic [CACHEADDRBITS-1:0] idx_t;

  state_t         state;
  logic [TW-1:0]  new_tag;
  logic [TW-1:0]  old_tag;
  logic [TW-1:0]  req_tag;
  logic           tag_valid;
  logic           miss_req;
  logic           wb_need;
  logic           cnt_clr;
  logic           cnt_inc;
  idx_t           cnt;
  idx_t           cnt_nxt;
  logic           last;
  logic           unused_addr;

  assign req_tag     = dcache_addr[ADDRBITS-1:TL];
  assign unused_addr = ^dcache_addr[TL-1:0];
  assign miss_req    = (dcache_rdreq | dcache_wrreq) & line_miss;
  assign wb_need     = line_dirty & tag_valid;

  assign dcache_stall = (state != S_IDLE) | miss_req;

  assign cnt_clr = (state == S_IDLE) & miss_req;
  assign cnt_inc = ((state == S_WB_REQ) & mem_ack)
                 | (state == S_FILL_WR);

  dcache_flush_ctrl_wordcnt #(
    .W(CACHEADDRBITS)
  ) u_wordcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .nxt     (cnt_nxt),
    .last    (last)
  );

  function automatic logic [ADDRBITS-1:0] waddr(
    input logic [TW-1:0] t,
    input idx_t          c
  );
    return {t, c, 2'b00};
  endfunction

  // Outputs are registered for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      new_tag    <= '0;
      old_tag    <= '0;
      tag_valid  <= 1'b0;
      flush_mode <= 1'b0;
      flush_we   <= 1'b0;
      flush_addr <= '0;
      flush_in   <= '0;
      mem_addr   <= '0;
      mem_rdreq  <= 1'b0;
      mem_wrreq  <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (miss_req) begin
            new_tag    <= req_tag;
            flush_mode <= 1'b1;
            if (wb_need) begin
              state      <= S_WB_RD;
              flush_addr <= waddr(old_tag, '0);
            end else begin
              state     <= S_FILL_REQ;
              mem_rdreq <= 1'b1;
              mem_addr  <= waddr(req_tag, '0);
            end
          end
        end
        S_WB_RD: begin
          state     <= S_WB_REQ;
          mem_wrreq <= 1'b1;
          mem_addr  <= waddr(old_tag, cnt);
          mem_wdata <= line_out;
        end
        S_WB_REQ: begin
          if (mem_ack) begin
            mem_wrreq <= 1'b0;
            if (last) begin
              state     <= S_FILL_REQ;
              mem_rdreq <= 1'b1;
              mem_addr  <= waddr(new_tag, '0);
            end else begin
              state      <= S_WB_RD;
              flush_addr <= waddr(old_tag, cnt_nxt);
            end
          end
        end
        S_FILL_REQ: begin
          if (mem_ack) begin
            state      <= S_FILL_WR;
            mem_rdreq  <= 1'b0;
            flush_in   <= mem_rdata;
            flush_we   <= 1'b1;
            flush_addr <= waddr(new_tag, cnt);
          end
        end
        S_FILL_WR: begin
          flush_we <= 1'b0;
          if (last) begin
            state <= S_DONE;
          end else begin
            state     <= S_FILL_REQ;
            mem_rdreq <= 1'b1;
            mem_addr  <= waddr(new_tag, cnt_nxt);
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          flush_mode <= 1'b0;
          old_tag    <= new_tag;
          tag_valid  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_FLUSH_PERFCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_miss <= '0;
      perf_wb   <= '0;
    end else if (cnt_clr) begin
      perf_miss <= perf_miss + 32'd1;
      if (wb_need) begin
        perf_wb <= perf_wb + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Self-checking bench for dcache_flush_ctrl (CACHEADDRBITS=2, N=4).
// Bench plays the cache line and main memory; expectations come from a word-level model.
module tb_dcache_flush_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] dcache_addr;
  logic        dcache_rdreq;
  logic        dcache_wrreq;
  logic        dcache_stall;
  logic        line_miss;
  logic        line_dirty;
  logic [31:0] line_out;
  logic        flush_mode;
  logic        flush_we;
  logic [31:0] flush_addr;
  logic [31:0] flush_in;
  logic [31:0] mem_addr;
  logic        mem_rdreq;
  logic        mem_wrreq;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_FLUSH_PERFCNT_EN
  logic [31:0] perf_miss;
  logic [31:0] perf_wb;
`endif

  dcache_flush_ctrl #(
    .DATABITS      (32),
    .ADDRBITS      (32),
    .CACHEADDRBITS (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dcache_addr  (dcache_addr),
    .dcache_rdreq (dcache_rdreq),
    .dcache_wrreq (dcache_wrreq),
    .dcache_stall (dcache_stall),
    .line_miss    (line_miss),
    .line_dirty   (line_dirty),
    .line_out     (line_out),
    .flush_mode   (flush_mode),
    .flush_we     (flush_we),
    .flush_addr   (flush_addr),
    .flush_in     (flush_in),
    .mem_addr     (mem_addr),
    .mem_rdreq    (mem_rdreq),
    .mem_wrreq    (mem_wrreq),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
`ifdef DCACHE_FLUSH_PERFCNT_EN
    ,
    .perf_miss    (perf_miss),
    .perf_wb      (perf_wb)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] line_data [N];
  logic [27:0] m_tag;
  bit          m_valid;
  req_t        expq [$];

  assign line_out = line_data[flush_addr[3:2]];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  // One CPU miss; dly<0 means random ack delay 0..3 per request.
  task automatic xact(input logic [31:0] addr, input bit wr,
                      input bit dirty, input int dly,
                      input int exp_stall);
    logic [27:0] nt;
    bit          wb;
    bit          pend;
    int          stall_n, fm_n, fills, cyc, wait_n, held, held_sum;
    req_t        cur;
    nt = addr[31:4];
    wb = dirty && m_valid;
    pend = 0;
    stall_n = 0; fm_n = 0; fills = 0; cyc = 0;
    wait_n = 0; held = 0; held_sum = 0;
    cur = '{0, 32'h0, 32'h0};
    expq.delete();
    if (wb)
      for (int i = 0; i < N; i++)
        expq.push_back('{1'b1, {m_tag, i[1:0], 2'b00}, line_data[i]});
    for (int i = 0; i < N; i++)
      expq.push_back('{1'b0, {nt, i[1:0], 2'b00},
                       mem_rd({nt, i[1:0], 2'b00})});
    @(negedge clk);
    dcache_addr  = addr;
    dcache_rdreq = !wr;
    dcache_wrreq = wr;
    line_dirty   = dirty;
    line_miss    = 1'b1;
    mem_ack      = 1'b0;
    #1 chk("stall_comb", dcache_stall, 1);
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!dcache_stall) break;
      stall_n++;
      if (flush_mode) fm_n++;
      if (flush_we) begin
        chk("fill_addr", flush_addr, {nt, fills[1:0], 2'b00});
        chk("fill_data", flush_in, mem_rd(flush_addr));
        line_data[flush_addr[3:2]] = flush_in;
        fills++;
        if (fills == N) begin
          m_tag     = nt;
          m_valid   = 1;
          line_miss = 1'b0;
        end
      end
      if (mem_rdreq || mem_wrreq) begin
        if (!pend) begin
          pend = 1;
          held = 0;
          chk("req_avail", expq.size() > 0, 1);
          if (expq.size() > 0) cur = expq.pop_front();
          chk("req_kind", {mem_wrreq, mem_rdreq}, {cur.wr, !cur.wr});
          chk("req_addr", mem_addr, cur.a);
          if (cur.wr) chk("wb_data", mem_wdata, cur.d);
          wait_n = (dly < 0) ? $urandom_range(0, 3) : dly;
        end else begin
          chk("req_hold", {mem_wrreq, mem_rdreq, mem_addr},
              {cur.wr, !cur.wr, cur.a});
        end
        held++;
        if (wait_n == 0) begin
          mem_ack = 1'b1;
          if (cur.wr) mem[cur.a] = mem_wdata;
          else mem_rdata = cur.d;
          pend = 0;
          held_sum += held;
          if (dly >= 0) chk("hold_cycles", held, dly + 1);
        end else begin
          wait_n--;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
    end
    chk("in_budget", cyc < 300, 1);
    chk("reqs_done", expq.size(), 0);
    chk("fill_count", fills, N);
    chk("stall_model", stall_n, (wb ? N : 0) + held_sum + N + 1);
    if (exp_stall > 0) chk("stall_len", stall_n, exp_stall);
    chk("fmode_len", fm_n, stall_n);
    dcache_rdreq = 1'b0;
    dcache_wrreq = 1'b0;
    mem_ack      = 1'b0;
  endtask

  task automatic reset_mid_wb(input logic [31:0] addr);
    int wr_seen, cyc;
    bit prev_wr;
    wr_seen = 0; cyc = 0; prev_wr = 0;
    @(negedge clk);
    dcache_addr  = addr;
    dcache_rdreq = 1'b1;
    line_dirty   = 1'b1;
    line_miss    = 1'b1;
    mem_ack      = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (mem_wrreq) begin
        if (!prev_wr) wr_seen++;
        if (wr_seen == 2) break;
        mem_ack = 1'b1;
      end
      prev_wr = mem_wrreq;
    end
    chk("rst_second_wb", wr_seen, 2);
    #2;
    reset_n      = 1'b0;
    dcache_rdreq = 1'b0;
    mem_ack      = 1'b0;
    #1;
    chk("rst_wrreq", mem_wrreq, 0);
    chk("rst_fmode", flush_mode, 0);
    chk("rst_stall", dcache_stall, 0);
    chk("rst_maddr", mem_addr, 0);
    m_valid = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stall"}, dcache_stall, 0);
    chk({tag, "_fmode"}, flush_mode, 0);
    chk({tag, "_fwe"}, flush_we, 0);
    chk({tag, "_faddr"}, flush_addr, 0);
    chk({tag, "_fin"}, flush_in, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mreq"}, {mem_rdreq, mem_wrreq}, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    logic [31:0] a;
    reset_n      = 1'b0;
    dcache_addr  = 32'h0;
    dcache_rdreq = 1'b0;
    dcache_wrreq = 1'b0;
    line_miss    = 1'b0;
    line_dirty   = 1'b0;
    mem_rdata    = 32'h0;
    mem_ack      = 1'b0;
    m_tag        = '0;
    m_valid      = 0;
    for (int i = 0; i < N; i++) line_data[i] = 32'h0;
    for (int i = 0; i < N; i++) mem[32'h100 + 4 * i] = 32'hA0 + i;
    repeat (2) @(negedge clk);
    chk_idle_outputs("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    xact(32'h100, 0, 0, 0, 2 * N + 1);
    for (int i = 0; i < N; i++)
      chk("line_a0", line_data[i], 32'hA0 + i);

    xact(32'h200, 1, 1, 0, 4 * N + 1);
    for (int i = 0; i < N; i++)
      chk("wb_mem", mem_rd(32'h100 + 4 * i), 32'hA0 + i);
`ifdef DCACHE_FLUSH_PERFCNT_EN
    chk("perf_miss", perf_miss, 2);
    chk("perf_wb", perf_wb, 1);
`endif

    xact(32'h300, 0, 0, 3, -1);

    for (int k = 0; k < 6; k++) begin
      do a = $urandom; while (a[31:4] == m_tag);
      xact(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           -1, -1);
    end

    do a = $urandom; while (a[31:4] == m_tag);
    reset_mid_wb(a);
    do a = $urandom; while (a[31:4] == m_tag);
    xact(a, 0, 1, 0, 2 * N + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
